// File: rtl/soqpsk_pkg.sv
// Shared SOQPSK-MIL definitions: ternary symbol encoding, PN15 constants
// and the 8-point phase-to-I/Q lookup.
package soqpsk_pkg;

  typedef logic [1:0] alpha_t;
  localparam alpha_t ALPHA_POS  = 2'b01;
  localparam alpha_t ALPHA_ZERO = 2'b00;
  localparam alpha_t ALPHA_NEG  = 2'b11;

  // x^15 + x^14 + 1: feedback from the two oldest register bits
  localparam int          PN_MSB   = 14;
  localparam int          PN_TAP   = 13;
  localparam logic [14:0] PN_SEED  = 15'h7FFF;

  typedef struct packed {
    logic signed [17:0] i;
    logic signed [17:0] q;
  } iq_t;

  // Phase in units of pi/4; a = axis magnitude, d = diagonal magnitude
  function automatic iq_t phase_lut(input logic [2:0] phase,
                                    input logic signed [17:0] a,
                                    input logic signed [17:0] d);
    iq_t r;
    case (phase)
      3'd0:    begin r.i = a;       r.q = 18'sd0;  end
      3'd1:    begin r.i = d;       r.q = d;       end
      3'd2:    begin r.i = 18'sd0;  r.q = a;       end
      3'd3:    begin r.i = -d;      r.q = d;       end
      3'd4:    begin r.i = -a;      r.q = 18'sd0;  end
      3'd5:    begin r.i = -d;      r.q = -d;      end
      3'd6:    begin r.i = 18'sd0;  r.q = -a;      end
      3'd7:    begin r.i = d;       r.q = -d;      end
      default: begin r.i = a;       r.q = 18'sd0;  end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/soqpsk_precoder.sv
// IRIG-106 SOQPSK ternary precoder: one bit in per strobe, registered
// ternary symbol and its reference bit out.
module soqpsk_precoder
  import soqpsk_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   strobe,
  input  logic   data_bit,
  output alpha_t alpha,
  output logic   ref_bit
);

  logic   hist1;
  logic   hist2;
  logic   parity;
  alpha_t alpha_next;

  // Bits stand for a = +1 (1) / -1 (0); the symbol is negative when an odd
  // number of the factors (-1)^(k+1), a_{k-1}, (a_k - a_{k-2}) are negative.
  always_comb begin
    alpha_next = ALPHA_ZERO;
    if (data_bit != hist2) begin
      if ((~parity) ^ (~hist1) ^ (~data_bit)) begin
        alpha_next = ALPHA_NEG;
      end else begin
        alpha_next = ALPHA_POS;
      end
    end else begin
      alpha_next = ALPHA_ZERO;
    end
  end

  // Symbol register, a-history and even/odd parity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist1   <= 1'b1;
      hist2   <= 1'b1;
      parity  <= 1'b0;
      alpha   <= ALPHA_ZERO;
      ref_bit <= 1'b0;
    end else if (strobe) begin
      alpha   <= alpha_next;
      ref_bit <= data_bit;
      hist2   <= hist1;
      hist1   <= data_bit;
      parity  <= ~parity;
    end
  end

endmodule

// File: rtl/soqpsk_mod.sv
// SOQPSK-MIL baseband modulator: bit source, ternary precoder, phase
// integrator at 2 samples/bit and registered I/Q with demodulator strobes.
module soqpsk_mod
  import soqpsk_pkg::*;
#(
  parameter int CLKS_PER_SYM = 9,
  parameter int AMP          = 65536,
  parameter int AMP_D        = 46341
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               srcSel,
  input  logic               dataIn,
  output logic               bitReq,
  output logic               symEn,
  output logic               sym2xEn,
  output logic signed [17:0] iOut,
  output logic signed [17:0] qOut,
  output logic [1:0]         alpha,
  output logic               refBit
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_SYM);
  localparam int                 HALF     = CLKS_PER_SYM / 2;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_SYM - 1);
  localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(HALF);
  localparam logic signed [17:0] AMP_S    = 18'(AMP);
  localparam logic signed [17:0] AMP_D_S  = 18'(AMP_D);

  logic [CNT_W-1:0] cnt;
  logic [14:0]      pn;
  logic             t0;
  logic             half_tick;
  logic             cur_bit;
  logic             upd;
  logic             upd_first;
  logic             smp;
  logic             smp_first;
  logic [2:0]       phase;
  iq_t              iq;

  // Reset gates the tick so bitReq stays low while reset is held
  assign t0        = en & ~reset & (cnt == '0);
  assign half_tick = t0 | (en & ~reset & (cnt == CNT_HALF));
  assign cur_bit   = srcSel ? pn[PN_MSB] : dataIn;
  assign bitReq    = t0;
  assign iq        = phase_lut(phase, AMP_S, AMP_D_S);

  soqpsk_precoder u_precoder (
    .clk      (clk),
    .reset    (reset),
    .strobe   (t0),
    .data_bit (cur_bit),
    .alpha    (alpha),
    .ref_bit  (refBit)
  );

  // PN15 source, advanced once per bit whether or not it is selected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pn <= PN_SEED;
    end else if (t0) begin
      pn <= {pn[13:0], pn[PN_MSB] ^ pn[PN_TAP]};
    end
  end

  // Bit counter and the two-stage half-tick pipeline: phase update, then I/Q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      upd       <= 1'b0;
      upd_first <= 1'b0;
      smp       <= 1'b0;
      smp_first <= 1'b0;
      phase     <= 3'd0;
      symEn     <= 1'b0;
      sym2xEn   <= 1'b0;
      iOut      <= 18'sd0;
      qOut      <= 18'sd0;
    end else if (en) begin
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      upd       <= half_tick;
      upd_first <= t0;
      if (upd) begin
        phase <= phase + {alpha[1], alpha};
      end
      smp       <= upd;
      smp_first <= upd_first;
      sym2xEn   <= smp;
      symEn     <= smp & smp_first;
      if (smp) begin
        iOut <= iq.i;
        qOut <= iq.q;
      end
    end else begin
      symEn   <= 1'b0;
      sym2xEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_soqpsk_mod.sv
// Self-checking bench for soqpsk_mod: table-driven pattern runs, random
// data / PN15 runs against a bit-level reference model, and hand sequences.
module tb_soqpsk_mod;

  localparam int  CPS  = 9;
  localparam int  HALF = CPS / 2;
  localparam int  A    = 65536;
  localparam int  D    = 46341;
  localparam real PI   = 3.14159265358979;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               srcSel;
  logic               dataIn;
  logic               bitReq;
  logic               symEn;
  logic               sym2xEn;
  logic signed [17:0] iOut;
  logic signed [17:0] qOut;
  logic [1:0]         alpha;
  logic               refBit;

  soqpsk_mod #(.CLKS_PER_SYM(CPS), .AMP(A), .AMP_D(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .srcSel  (srcSel),
    .dataIn  (dataIn),
    .bitReq  (bitReq),
    .symEn   (symEn),
    .sym2xEn (sym2xEn),
    .iOut    (iOut),
    .qOut    (qOut),
    .alpha   (alpha),
    .refBit  (refBit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: enabled edges since reset, bit index, a-history,
  // current ternary symbol, phase (units of pi/4) and PN read index.
  int m_edges, m_k, m_am1, m_am2, m_alpha, m_phase, m_pn_idx;
  int pn_seq [0:4095];
  logic [1:0] x_alpha;
  logic       x_ref, x_sym, x_sx;
  int         x_i, x_q;

  typedef struct {
    logic [3:0] pat;
    logic       src;
    int         nbits;
    logic [1:0] exp_alpha;
    logic       exp_ref;
    int         exp_i;
    int         exp_q;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [1:0] enc(input int a);
    return (a > 0) ? 2'b01 : ((a < 0) ? 2'b11 : 2'b00);
  endfunction

  function automatic logic pat_bit(input logic [3:0] pat, input int k);
    logic [3:0] p;
    p = pat;
    return p[k % 4];
  endfunction

  task automatic model_reset();
    m_edges = 0; m_k = 0; m_am1 = 1; m_am2 = 1; m_alpha = 0;
    m_phase = 0; m_pn_idx = 0;
    x_alpha = 2'b00; x_ref = 1'b0; x_sym = 1'b0; x_sx = 1'b0;
    x_i = 0; x_q = 0;
  endtask

  // One clock: drive, check bitReq, advance model on the edge, check outputs
  task automatic step(input logic en_v, input logic din_v, output logic br);
    int r, b, a;
    en = en_v;
    dataIn = din_v;
    #1;
    br = bitReq;
    check("bitReq", bitReq, (en_v && (m_edges % CPS == 0)) ? 1 : 0);
    @(posedge clk);
    x_sym = 1'b0;
    x_sx  = 1'b0;
    if (en_v) begin
      r = m_edges % CPS;
      if (r == 0) begin
        b = srcSel ? pn_seq[m_pn_idx] : int'(din_v);
        m_pn_idx++;
        a = (b != 0) ? 1 : -1;
        m_alpha = ((m_k % 2 == 0) ? -1 : 1) * m_am1 * (a - m_am2) / 2;
        m_am2 = m_am1;
        m_am1 = a;
        m_k++;
        x_ref   = (b != 0);
        x_alpha = enc(m_alpha);
      end
      if (r == 2 || r == HALF + 2) begin
        m_phase = (m_phase + m_alpha + 8) % 8;
        x_sx  = 1'b1;
        x_sym = (r == 2);
        x_i   = rnd(A * $cos(m_phase * PI / 4.0));
        x_q   = rnd(A * $sin(m_phase * PI / 4.0));
      end
      m_edges++;
    end
    #1;
    check("symEn", symEn, x_sym);
    check("sym2xEn", sym2xEn, x_sx);
    check("alpha", alpha, x_alpha);
    check("refBit", refBit, x_ref);
    check("iOut", iOut, x_i);
    check("qOut", qOut, x_q);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_bitReq", bitReq, 0);
    check("rst_symEn", symEn, 0);
    check("rst_sym2xEn", sym2xEn, 0);
    check("rst_alpha", alpha, 0);
    check("rst_refBit", refBit, 0);
    check("rst_iOut", iOut, 0);
    check("rst_qOut", qOut, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic br;
  int   gap, seen;
  logic have_prev;
  logic en_v;

  initial begin
    reset = 1'b1; en = 1'b0; srcSel = 1'b0; dataIn = 1'b0;
    for (int j = 0; j < 4096; j++)
      pn_seq[j] = (j < 15) ? 1 : (pn_seq[j-15] ^ pn_seq[j-14]);

    // Bit k of a pattern is pat[k%4]. A period-2 input leaves the symbol at 0
    // in steady state, but the +1,+1 reset history gives 1010 one -1 symbol
    // at k=1, and the 16th PN15 bit (first 0) gives -1 at k=15.
    tbl[0] = '{4'b1111, 1'b0, 16, 2'b00, 1'b1, 65536, 0};
    tbl[1] = '{4'b0101, 1'b0, 16, 2'b00, 1'b0, 0, -65536};
    tbl[2] = '{4'b0011, 1'b0, 16, 2'b01, 1'b0, -65536, 0};
    tbl[3] = '{4'b0000, 1'b1, 16, 2'b11, 1'b0, 0, -65536};

    #2;
    for (int t = 0; t < 4; t++) begin
      srcSel = tbl[t].src;
      do_reset();
      for (int e = 0; e < tbl[t].nbits * CPS; e++)
        step(1'b1, pat_bit(tbl[t].pat, e / CPS), br);
      check("tbl_alpha", alpha, tbl[t].exp_alpha);
      check("tbl_refBit", refBit, tbl[t].exp_ref);
      check("tbl_iOut", iOut, tbl[t].exp_i);
      check("tbl_qOut", qOut, tbl[t].exp_q);
    end

    // 1100 from reset: first +1 sample (D,D), next sample (0,A)
    srcSel = 1'b0;
    do_reset();
    for (int e = 0; e < 25; e++) begin
      step(1'b1, pat_bit(4'b0011, e / CPS), br);
      if (e == 20) begin
        check("p1_iOut", iOut, 46341);
        check("p1_qOut", qOut, 46341);
      end
      if (e == 24) begin
        check("p2_iOut", iOut, 0);
        check("p2_qOut", qOut, 65536);
      end
    end

    // Reset mid-bit with phase 2, then restart with a 0 bit (alpha = +1)
    do_reset();
    step(1'b1, 1'b0, br);
    check("rst_first_alpha", alpha, 2'b01);
    step(1'b1, 1'b0, br);
    step(1'b1, 1'b0, br);
    check("rst_first_i", iOut, 46341);
    check("rst_first_q", qOut, 46341);

    // en dropped for 5 clocks at cnt==3; T0 spacing counted in enabled cycles
    do_reset();
    gap = 0; seen = 0; have_prev = 1'b0;
    for (int s = 0; s < 45; s++) begin
      en_v = !(s >= 21 && s < 26);
      step(en_v, 1'(($urandom % 2)), br);
      if (br) begin
        if (have_prev) check("t0_gap", gap, CPS);
        have_prev = 1'b1;
        gap = 0;
        seen++;
      end
      if (en_v) gap++;
    end
    check("t0_seen", seen, 5);

    // Random external data with random en gaps
    do_reset();
    for (int e = 0; e < 300 * CPS; e++)
      step(($urandom_range(0, 9) != 0), 1'(($urandom % 2)), br);

    // PN15 source with random en gaps
    srcSel = 1'b1;
    do_reset();
    for (int e = 0; e < 200 * CPS; e++)
      step(($urandom_range(0, 7) != 0), 1'(($urandom % 2)), br);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
